spi_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one SPI driver between N_REQ requesters. It accepts per-requester transfer commands (bit count plus TX word), launches them one at a time through the driver's start/ready handshake, and returns the captured RX word with a per-requester completion pulse. It sits between client logic and the SPI driver and runs in the SCLK domain.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_arbiter_rr_pick.sv | 34 +++
 rtl/spi_arbiter.sv | 128 ++++++++++++
 tb/tb_spi_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI arbiter slice.
`default_nettype none

package spi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } spi_arb_state_t;

    function automatic int cw_f(input int maxlen);
        return $clog2(maxlen) + 1;
    endfunction

    function automatic logic n_clks_valid(input int n, input int maxlen);
        return (n >= 1) && (n <= maxlen);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any_req
);

    int j;

    always_comb begin
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                idx     = IW'(j);
            end
        end
        grant = any_req ? (N_REQ'(1) << idx) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/spi_arbiter.sv
// Round-robin sequencer sharing one SPI driver between N_REQ requesters.
`default_nettype none

module spi_arbiter
    import spi_pkg::*;
#(
    parameter int  N_REQ        = 4,
    parameter int  SPI_MAXLEN   = 16,
    parameter int  BUSY_TIMEOUT = 8,
    localparam int CW           = cw_f(SPI_MAXLEN)
) (
    input  logic                        sresetn,
    input  logic                        SCLK,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*CW-1:0]         req_n_clks,
    input  logic [N_REQ*SPI_MAXLEN-1:0] req_tx_data,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            done,
    output logic                        err,
    output logic [SPI_MAXLEN-1:0]       rx_data,
    output logic                        busy,
    output logic                        drv_start,
    input  logic                        drv_rdy,
    output logic [CW-1:0]               drv_n_clks,
    output logic [SPI_MAXLEN-1:0]       drv_tx_data,
    input  logic [SPI_MAXLEN-1:0]       drv_rx_data
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    spi_arb_state_t  state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic            err_flag;
    logic [TW-1:0]   cnt;

    logic [N_REQ-1:0]      pick_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic [CW-1:0]         sel_n;
    logic [SPI_MAXLEN-1:0] sel_tx;
    logic                  sel_valid;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign sel_n     = req_n_clks[pick_idx*CW +: CW];
    assign sel_tx    = req_tx_data[pick_idx*SPI_MAXLEN +: SPI_MAXLEN];
    assign sel_valid = n_clks_valid(int'(sel_n), SPI_MAXLEN);

    always_ff @(posedge SCLK or negedge sresetn) begin
        if (!sresetn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            err_flag    <= 1'b0;
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            err         <= 1'b0;
            rx_data     <= '0;
            busy        <= 1'b0;
            drv_start   <= 1'b0;
            drv_n_clks  <= '0;
            drv_tx_data <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        busy  <= 1'b1;
                        if (sel_valid) begin
                            gnt         <= pick_grant;
                            drv_start   <= 1'b1;
                            drv_n_clks  <= sel_n;
                            drv_tx_data <= sel_tx;
                            cnt         <= '0;
                            err_flag    <= 1'b0;
                            state       <= WAIT_BUSY;
                        end else begin
                            err_flag <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                WAIT_BUSY: begin
                    // Driver acceptance wins over a timeout landing on the same edge.
                    if (!drv_rdy) begin
                        drv_start <= 1'b0;
                        state     <= WAIT_DONE;
                    end else if (cnt == TW'(BUSY_TIMEOUT - 1)) begin
                        drv_start <= 1'b0;
                        err_flag  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (drv_rdy) begin
                        rx_data <= drv_rx_data;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    done   <= N_REQ'(1) << owner;
                    err    <= err_flag;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a behavioural SPI driver model.
`default_nettype none

module tb_spi_arbiter;

    localparam int N  = 4;
    localparam int ML = 16;
    localparam int CW = 5;

    logic              SCLK;
    logic              sresetn;
    logic [N-1:0]      req;
    logic [N*CW-1:0]   req_n_clks;
    logic [N*ML-1:0]   req_tx_data;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic              err;
    logic [ML-1:0]     rx_data;
    logic              busy;
    logic              drv_start;
    logic              drv_rdy;
    logic [CW-1:0]     drv_n_clks;
    logic [ML-1:0]     drv_tx_data;
    logic [ML-1:0]     drv_rx_data;

    spi_arbiter #(.N_REQ(N), .SPI_MAXLEN(ML), .BUSY_TIMEOUT(8)) dut (
        .sresetn     (sresetn),
        .SCLK        (SCLK),
        .req         (req),
        .req_n_clks  (req_n_clks),
        .req_tx_data (req_tx_data),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rx_data     (rx_data),
        .busy        (busy),
        .drv_start   (drv_start),
        .drv_rdy     (drv_rdy),
        .drv_n_clks  (drv_n_clks),
        .drv_tx_data (drv_tx_data),
        .drv_rx_data (drv_rx_data)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    typedef struct {
        int          idx;
        logic [CW-1:0] n;
        logic [ML-1:0] tx;
        bit          e;
        bit          launch;
    } exp_t;

    exp_t sb[$];

    int            n_vec = 0;
    int            n_miss = 0;
    int            done_seen = 0;
    int            cyc = 0;
    int            last_done_cyc = 0;
    int            start_len = 0;
    bit            have_done = 0;
    bit            chk_b2b = 0;
    bit            drv_stuck = 0;
    logic          start_d = 1'b0;
    logic [ML-1:0] last_rx = '0;

    // Driver model: drop rdy one cycle after seeing start, hold low n_clks cycles.
    int            dm_state = 0;
    int            dm_cnt = 0;
    logic [ML-1:0] dm_tx = '0;

    always @(negedge SCLK) begin
        if (!sresetn) begin
            dm_state = 0;
            drv_rdy  = 1'b1;
        end else begin
            case (dm_state)
                0: if (drv_start && !drv_stuck) begin
                    dm_cnt   = int'(drv_n_clks);
                    dm_tx    = drv_tx_data;
                    dm_state = 1;
                end
                1: begin
                    drv_rdy  = 1'b0;
                    dm_state = 2;
                end
                default: begin
                    dm_cnt = dm_cnt - 1;
                    if (dm_cnt <= 0) begin
                        drv_rx_data = dm_tx ^ 16'h00FF;
                        drv_rdy     = 1'b1;
                        dm_state    = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: launch checks, start width, and done/err scoreboard pops.
    always @(negedge SCLK) begin
        exp_t          e;
        logic [ML-1:0] exp_rx;
        int            exp_len;
        if (sresetn) begin
            cyc++;
            if (drv_start && !start_d) begin
                n_vec++;
                if (sb.size() == 0 || !sb[0].launch) begin
                    n_miss++;
                    $display("FAIL launch: unexpected drv_start gnt=%b", gnt);
                end else if (gnt !== (4'b0001 << sb[0].idx) || drv_n_clks !== sb[0].n
                             || drv_tx_data !== sb[0].tx) begin
                    n_miss++;
                    $display("FAIL launch: gnt=%b n=%0d tx=%h, required gnt=%b n=%0d tx=%h",
                             gnt, drv_n_clks, drv_tx_data, 4'b0001 << sb[0].idx, sb[0].n, sb[0].tx);
                end
                if (chk_b2b && have_done) begin
                    n_vec++;
                    if (cyc - last_done_cyc != 1) begin
                        n_miss++;
                        $display("FAIL b2b_gap: %0d cycles from done to start, required 1",
                                 cyc - last_done_cyc);
                    end
                end
            end
            if (drv_start) start_len++;
            if (!drv_start && start_d) begin
                exp_len = drv_stuck ? 8 : 2;
                n_vec++;
                if (start_len != exp_len) begin
                    n_miss++;
                    $display("FAIL start_width: %0d cycles, required %0d", start_len, exp_len);
                end
                start_len = 0;
            end
            if (done !== '0) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL done: unexpected done=%b", done);
                end else begin
                    e      = sb.pop_front();
                    exp_rx = e.e ? last_rx : (e.tx ^ 16'h00FF);
                    if (done !== (4'b0001 << e.idx) || err !== e.e || rx_data !== exp_rx
                        || gnt !== '0 || busy !== 1'b0) begin
                        n_miss++;
                        $display("FAIL done: done=%b err=%b rx=%h gnt=%b busy=%b, required done=%b err=%b rx=%h gnt=0 busy=0",
                                 done, err, rx_data, gnt, busy, 4'b0001 << e.idx, e.e, exp_rx);
                    end
                    last_rx = exp_rx;
                end
                done_seen++;
                last_done_cyc = cyc;
                have_done     = 1;
            end else if (err !== 1'b0) begin
                n_vec++;
                n_miss++;
                $display("FAIL err_alone: err=%b with done=0, required 0", err);
            end
            start_d = drv_start;
        end else begin
            start_d   = 1'b0;
            start_len = 0;
        end
    end

    task automatic set_cmd(input int i, input int n, input logic [ML-1:0] tx);
        req_n_clks[i*CW +: CW]  = CW'(n);
        req_tx_data[i*ML +: ML] = tx;
    endtask

    task automatic push(input int i, input int n, input logic [ML-1:0] tx, input bit e, input bit l);
        exp_t x;
        x.idx = i; x.n = CW'(n); x.tx = tx; x.e = e; x.launch = l;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(negedge SCLK);
        #1;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int k = 0;
        while (done_seen < target && k < budget) begin
            tick();
            k++;
        end
        if (done_seen < target) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: timeout, %0d dones seen, required %0d", name, done_seen, target);
        end
    endtask

    task automatic test_reset();
        sresetn = 1'b0;
        req = '0; req_n_clks = '0; req_tx_data = '0;
        drv_rdy = 1'b1; drv_rx_data = '0;
        repeat (3) tick();
        n_vec++;
        if ({gnt, done, err, busy, drv_start} !== '0) begin
            n_miss++;
            $display("FAIL reset_ctrl: gnt=%b done=%b err=%b busy=%b start=%b, required all 0",
                     gnt, done, err, busy, drv_start);
        end
        n_vec++;
        if ({rx_data, drv_n_clks, drv_tx_data} !== '0) begin
            n_miss++;
            $display("FAIL reset_data: rx=%h n=%0d tx=%h, required 0", rx_data, drv_n_clks, drv_tx_data);
        end
        sresetn = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        int base = done_seen;
        set_cmd(0, 4, 16'h1100);
        set_cmd(1, 6, 16'h2211);
        set_cmd(3, 16, 16'h4433);
        push(0, 4, 16'h1100, 0, 1);
        push(1, 6, 16'h2211, 0, 1);
        push(3, 16, 16'h4433, 0, 1);
        push(0, 4, 16'h1100, 0, 1);
        req = 4'b1011;
        wait_dones(base + 4, 300, "contention");
        req = '0;
    endtask

    task automatic test_single();
        int base = done_seen;
        set_cmd(1, 8, 16'h00A5);
        push(1, 8, 16'h00A5, 0, 1);
        req = 4'b0010;
        wait_dones(base + 1, 100, "single");
        req = '0;
        n_vec++;
        if (rx_data !== 16'h005A) begin
            n_miss++;
            $display("FAIL single_rx: rx=%h, required 005a", rx_data);
        end
    endtask

    task automatic test_invalid();
        int lens[2] = '{0, 17};
        foreach (lens[t]) begin
            int k = 0;
            set_cmd(2, lens[t], 16'hDEAD);
            push(2, lens[t], 16'hDEAD, 1, 0);
            req = 4'b0100;
            do begin
                tick();
                k++;
            end while (done === '0 && k < 20);
            req = '0;
            n_vec++;
            if (k != 2 || done !== 4'b0100 || err !== 1'b1) begin
                n_miss++;
                $display("FAIL invalid_n%0d: done after %0d cycles done=%b err=%b, required 2 cycles done=0100 err=1",
                         lens[t], k, done, err);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int base = done_seen;
        drv_stuck = 1;
        set_cmd(0, 5, 16'h0101);
        set_cmd(3, 7, 16'h0303);
        push(3, 7, 16'h0303, 1, 1);
        push(0, 5, 16'h0101, 1, 1);
        req = 4'b1001;
        wait_dones(base + 2, 100, "timeout");
        req = '0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || drv_start !== 1'b0) begin
            n_miss++;
            $display("FAIL timeout_idle: busy=%b start=%b, required 0 0", busy, drv_start);
        end
        drv_stuck = 0;
    endtask

    task automatic test_withdraw();
        int base = done_seen;
        int k = 0;
        set_cmd(3, 5, 16'hBEEF);
        push(3, 5, 16'hBEEF, 0, 1);
        req = 4'b1000;
        do begin
            tick();
            k++;
        end while (!(busy && !drv_start && !drv_rdy) && k < 20);
        req = '0;
        set_cmd(3, 0, 16'h0000);
        wait_dones(base + 1, 50, "withdraw");
    endtask

    task automatic test_back_to_back();
        int base = done_seen;
        set_cmd(0, 1, 16'hA000);
        set_cmd(1, 2, 16'hB001);
        set_cmd(2, 3, 16'hC002);
        set_cmd(3, 1, 16'hD003);
        for (int i = 0; i < N; i++) push(i, (i == 3) ? 1 : i + 1, 16'hA000 + 16'h1001 * 16'(i), 0, 1);
        have_done = 0;
        chk_b2b   = 1;
        req = 4'b1111;
        wait_dones(base + 4, 200, "back_to_back");
        req = '0;
        chk_b2b = 0;
    endtask

    task automatic test_reset_mid();
        int base;
        int k = 0;
        set_cmd(2, 8, 16'h1234);
        push(2, 8, 16'h1234, 0, 1);
        req = 4'b0100;
        do begin
            tick();
            k++;
        end while (!(busy && !drv_start && !drv_rdy) && k < 20);
        sresetn = 1'b0;
        #1;
        n_vec++;
        if ({gnt, done, err, busy, drv_start} !== '0 || {rx_data, drv_n_clks, drv_tx_data} !== '0) begin
            n_miss++;
            $display("FAIL reset_mid: gnt=%b busy=%b start=%b rx=%h n=%0d tx=%h, required all 0",
                     gnt, busy, drv_start, rx_data, drv_n_clks, drv_tx_data);
        end
        req = '0;
        sb.delete();
        last_rx = '0;
        repeat (2) tick();
        sresetn = 1'b1;
        tick();
        base = done_seen;
        set_cmd(0, 3, 16'h0F0F);
        push(0, 3, 16'h0F0F, 0, 1);
        req = 4'b0001;
        wait_dones(base + 1, 50, "after_reset");
        req = '0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_invalid();
        test_timeout();
        test_withdraw();
        test_back_to_back();
        test_reset_mid();
        repeat (3) tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
